// File: rtl/mod_dec_inv_cipher_iter.sv
// Iterative AES-256 inverse cipher, one round per clock; InvSubBytes and round keys are external.
// Optional AES_DEC_ZEROIZE_EN clears the state register on the DONE->IDLE handshake.
module mod_dec_inv_cipher_iter #(
  parameter int unsigned NR = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] ct      [15:0],
  output logic [3:0] rk_addr,
  input  logic [7:0] rk      [15:0],
  output logic [7:0] isb_in  [15:0],
  input  logic [7:0] isb_out [15:0],
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] pt      [15:0],
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  fsm_t       fsm_q, fsm_d;
  logic [7:0] state_q [15:0];
  logic [7:0] state_d [15:0];
  logic [7:0] ark     [15:0];
  logic [3:0] round_q, round_d;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // {x*0e, x*0d, x*0b, x*09} from a single xtime chain
  function automatic logic [31:0] mulset(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x4 ^ b, x8 ^ x2 ^ b, x8 ^ b};
  endfunction

  // Returns {out3, out2, out1, out0} for one column
  function automatic logic [31:0] inv_mix_col(input logic [7:0] a0, input logic [7:0] a1,
                                              input logic [7:0] a2, input logic [7:0] a3);
    logic [31:0] p0, p1, p2, p3;
    p0 = mulset(a0);
    p1 = mulset(a1);
    p2 = mulset(a2);
    p3 = mulset(a3);
    return {p0[15:8]  ^ p1[23:16] ^ p2[7:0]   ^ p3[31:24],
            p0[23:16] ^ p1[7:0]   ^ p2[31:24] ^ p3[15:8],
            p0[7:0]   ^ p1[31:24] ^ p2[15:8]  ^ p3[23:16],
            p0[31:24] ^ p1[15:8]  ^ p2[23:16] ^ p3[7:0]};
  endfunction

  // InvShiftRows: byte (r,c) comes from (r, c-r mod 4); index is {column,row}
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      isb_in[4'(i)] = state_q[{2'(i[3:2] - i[1:0]), i[1:0]}];
    end
  end

  always_comb begin
    logic [31:0] col;
    col     = '0;
    fsm_d   = fsm_q;
    round_d = round_q;
    rk_addr = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      ark[4'(i)]     = isb_out[4'(i)] ^ rk[4'(i)];
      state_d[4'(i)] = state_q[4'(i)];
    end
    case (fsm_q)
      IDLE: begin
        rk_addr = 4'(NR);
        if (in_valid) begin
          for (int unsigned i = 0; i < 16; i++) begin
            state_d[4'(i)] = ct[4'(i)] ^ rk[4'(i)];
          end
          round_d = 4'(NR - 1);
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        rk_addr = round_q;
        for (int unsigned c = 0; c < 4; c++) begin
          col = inv_mix_col(ark[4'(4*c)], ark[4'(4*c+1)], ark[4'(4*c+2)], ark[4'(4*c+3)]);
          state_d[4'(4*c)]   = col[7:0];
          state_d[4'(4*c+1)] = col[15:8];
          state_d[4'(4*c+2)] = col[23:16];
          state_d[4'(4*c+3)] = col[31:24];
        end
        round_d = round_q - 4'd1;
        if (round_q == 4'd1) fsm_d = FINAL;
      end
      FINAL: begin
        rk_addr = '0;
        for (int unsigned i = 0; i < 16; i++) begin
          state_d[4'(i)] = ark[4'(i)];
        end
        fsm_d = DONE;
      end
      DONE: begin
        rk_addr = '0;
        if (out_ready) begin
          fsm_d = IDLE;
`ifdef AES_DEC_ZEROIZE_EN
          for (int unsigned i = 0; i < 16; i++) begin
            state_d[4'(i)] = '0;
          end
`endif
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      round_q <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        state_q[4'(i)] <= '0;
      end
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      for (int unsigned i = 0; i < 16; i++) begin
        state_q[4'(i)] <= state_d[4'(i)];
      end
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  assign pt        = state_q;

endmodule

// File: doc/mod_dec_inv_cipher_iter.md
# mod_dec_inv_cipher_iter

Iterative AES-256 inverse cipher. Accepts one 128-bit ciphertext block, applies the 14-round decryption sequence at one round per clock, and returns the plaintext block. It is the decryption-side counterpart of the encryption round datapath. Round keys come from the shared expanded-key store; InvSubBytes is performed by an external combinational inverse S-box.

## Interface
Parameters:
- NR, 14, number of rounds. Fixed for AES-256; other values are unsupported.

Ports (byte arrays are `[7:0] x [15:0]`; byte i = row (i%4), column (i/4); byte 0 is the first byte on the wire):
- clk  in  1  clock; all flops rise-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  ciphertext valid.
- in_ready  out  1  block can accept a ciphertext.
- ct  in  8x16  ciphertext.
- rk_addr  out  4  round-key index 0..14.
- rk  in  8x16  round key for rk_addr, combinational same-cycle read.
- isb_in  out  8x16  input to the inverse S-box.
- isb_out  in  8x16  inverse S-box result of isb_in, combinational.
- out_valid  out  1  plaintext valid.
- out_ready  in  1  consumer accepts plaintext.
- pt  out  8x16  plaintext (state register).
- busy  out  1  high in ROUND, FINAL, DONE.

## Operation
- States: IDLE, ROUND, FINAL, DONE. There is a 128-bit state register and a 4-bit round counter.
- IDLE:
  - in_ready=1 and rk_addr=14.
  - On in_valid&in_ready: state<=ct^rk, round<=13, go to ROUND.
- ROUND:
  - rk_addr=round.
  - state <= InvMixColumns(isb_out ^ rk).
  - round decrements each cycle; after round==1, go to FINAL.
- FINAL:
  - rk_addr=0.
  - state <= isb_out ^ rk.
  - Go to DONE.
- DONE:
  - out_valid=1 and pt=state.
  - On out_ready, go to IDLE.
  - While waiting, pt is stable and ct/in_valid are ignored.
- isb_in = InvShiftRows(state) in every state.
  - InvShiftRows: out[r+4c] = in[r+4*((c-r) mod 4)].
- InvMixColumns: per column, matrix rows {0e,0b,0d,09} rotated. Arithmetic is GF(2^8) with polynomial 0x11b, built from xtime chains. No multipliers.
- Only rk_addr values 0..14 are ever driven.

## Timing
- Reset values (while rst is high and after release): state=0, round=0, fsm=IDLE, in_ready=1, out_valid=0, pt=0, rk_addr=14, busy=0, isb_in=0.
- Latency:
  - Accept at edge E.
  - ROUND occupies edges E+1..E+13.
  - FINAL occupies edge E+14.
  - out_valid is high after edge E+14 (14 cycles).
- Throughput: with out_ready held high, the output handshake occurs at E+15 and the next accept at E+16. The minimum spacing is 16 cycles per block.
- rk_addr sequence, one value per cycle from IDLE: 14,13,...,1,0.
- in_valid outside IDLE has no effect. A ciphertext is never queued.
- out_ready outside DONE has no effect.
- Reset asserted in any state, including mid-ROUND: all registers return to reset values immediately. The block in flight is discarded and no out_valid is produced for it.

## Configuration
- AES_DEC_ZEROIZE_EN defined: on the DONE→IDLE transition, state<=0, so pt reads 0 in IDLE.
- AES_DEC_ZEROIZE_EN undefined: state holds the last plaintext until the next accept.

## Test plan
- FIPS-197 C.3 vector:
  - Stimulus: key store 000102…1f expanded, ct=8ea2b7ca516745bfeafc49904b496089.
  - Response: pt=00112233445566778899aabbccddeeff; out_valid exactly 14 cycles after accept.
- Zero vector:
  - Stimulus: all-zero key, ct=dc95c078a2408989ad48a21492842087.
  - Response: pt=all zeros.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles in DONE, with in_valid=1 and a new ct.
  - Response: pt stable, in_ready=0, new ct not taken; accepted only after the out_ready handshake.
- Back-to-back:
  - Stimulus: two blocks, out_ready=1, in_valid=1 continuously.
  - Response: accepts 16 cycles apart; rk_addr trace 14..0 per block; both plaintexts correct.
- Mid-operation reset:
  - Stimulus: pulse rst when round==7.
  - Response: out_valid=0, in_ready=1, rk_addr=14 immediately. The next block decrypts correctly with no stale output.
- Macro check:
  - With AES_DEC_ZEROIZE_EN: pt=0 the cycle after the output handshake.
  - Without it: pt retains the plaintext.
